// File: rtl/sdn_parser_hdr_fetch.sv
// rtl/sdn_parser_hdr_fetch.sv - SDN parser ingress header fetch: captures the first HDR_BEATS beats of each packet
module sdn_parser_hdr_fetch #(
    parameter int PRS_RX_DATA_W = 512,
    parameter int PRS_RX_KEEP_W = PRS_RX_DATA_W / 8,
    parameter int HDR_BEATS     = 2,
    parameter int LEN_W         = 16,
    parameter int MIN_PKT_BYTES = 14,
    parameter int DROP_MODE     = 0
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               parser_axis_rx_tvalid_i,
    input  logic [PRS_RX_DATA_W-1:0]           parser_axis_rx_tdata_i,
    input  logic [PRS_RX_KEEP_W-1:0]           parser_axis_rx_tkeep_i,
    input  logic                               parser_axis_rx_tlast_i,
    output logic                               parser_axis_rx_tready_o,
    output logic                               parser_axis_rx_tdrop_o,
    output logic                               hdr_valid_o,
    input  logic                               hdr_ready_i,
    output logic [HDR_BEATS*PRS_RX_DATA_W-1:0] hdr_data_o,
    output logic [LEN_W-1:0]                   hdr_len_o,
    output logic [LEN_W-1:0]                   pkt_len_o,
    output logic [31:0]                        drop_cnt_o
);

    localparam int IDX_W     = $clog2(HDR_BEATS + 1);
    localparam int CNT_W     = $clog2(PRS_RX_KEEP_W + 1);
    localparam int WIN_BYTES = HDR_BEATS * PRS_RX_KEEP_W;

    typedef enum logic [1:0] {IDLE, CAPT, SKIP, DROP} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         beat_idx;
    logic [IDX_W-1:0]         idx_next;
    logic [LEN_W-1:0]         byte_cnt;
    logic [LEN_W-1:0]         cnt_base;
    logic [LEN_W:0]           beat_bytes;
    logic [LEN_W:0]           cnt_sum;
    logic [LEN_W-1:0]         next_cnt;
    logic [LEN_W-1:0]         win_len;
    logic [PRS_RX_DATA_W-1:0] masked_data;
    logic                     beat_fire;
    logic                     hdr_accept;
    logic                     start_drop;
    logic                     is_drop;

    function automatic logic [CNT_W-1:0] popcount(input logic [PRS_RX_KEEP_W-1:0] k);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < PRS_RX_KEEP_W; i++) begin
            c = c + CNT_W'(k[i]);
        end
        return c;
    endfunction

    // Only a new packet start can be stalled, and only while the held header is not being taken.
    assign parser_axis_rx_tready_o = !((state == IDLE) && (DROP_MODE == 0) && hdr_valid_o && !hdr_ready_i);

    assign beat_fire  = parser_axis_rx_tvalid_i && parser_axis_rx_tready_o;
    assign hdr_accept = hdr_valid_o && hdr_ready_i;
    assign start_drop = (state == IDLE) && (DROP_MODE != 0) && hdr_valid_o;
    assign idx_next   = beat_idx + 1'b1;

    // Bytes beyond tkeep on the last beat are zeroed so the window never carries stale data.
    always_comb begin
        masked_data = parser_axis_rx_tdata_i;
        for (int i = 0; i < PRS_RX_KEEP_W; i++) begin
            if (parser_axis_rx_tlast_i && !parser_axis_rx_tkeep_i[i]) begin
                masked_data[i*8 +: 8] = 8'h00;
            end
        end
    end

    always_comb begin
        cnt_base   = (state == IDLE) ? '0 : byte_cnt;
        beat_bytes = parser_axis_rx_tlast_i ? (LEN_W+1)'(popcount(parser_axis_rx_tkeep_i))
                                            : (LEN_W+1)'(PRS_RX_KEEP_W);
        cnt_sum    = {1'b0, cnt_base} + beat_bytes;
        next_cnt   = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
        win_len    = (next_cnt < LEN_W'(WIN_BYTES)) ? next_cnt : LEN_W'(WIN_BYTES);
        is_drop    = (state == DROP) || start_drop || (next_cnt < LEN_W'(MIN_PKT_BYTES));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state                  <= IDLE;
            beat_idx               <= '0;
            byte_cnt               <= '0;
            parser_axis_rx_tdrop_o <= 1'b0;
            hdr_valid_o            <= 1'b0;
            hdr_data_o             <= '0;
            hdr_len_o              <= '0;
            pkt_len_o              <= '0;
            drop_cnt_o             <= '0;
        end else begin
            parser_axis_rx_tdrop_o <= 1'b0;
            if (hdr_accept) begin
                hdr_valid_o <= 1'b0;
            end
            if (beat_fire) begin
                byte_cnt <= next_cnt;
                case (state)
                    IDLE: begin
                        if (start_drop) begin
                            state <= DROP;
                        end else begin
                            for (int k = 0; k < HDR_BEATS; k++) begin
                                hdr_data_o[k*PRS_RX_DATA_W +: PRS_RX_DATA_W] <= (k == 0) ? masked_data : '0;
                            end
                            beat_idx <= IDX_W'(1);
                            state    <= (HDR_BEATS == 1) ? SKIP : CAPT;
                        end
                    end
                    CAPT: begin
                        for (int k = 0; k < HDR_BEATS; k++) begin
                            if (IDX_W'(k) == beat_idx) begin
                                hdr_data_o[k*PRS_RX_DATA_W +: PRS_RX_DATA_W] <= masked_data;
                            end
                        end
                        beat_idx <= idx_next;
                        if (idx_next == IDX_W'(HDR_BEATS)) begin
                            state <= SKIP;
                        end
                    end
                    default: begin
                    end
                endcase
                if (parser_axis_rx_tlast_i) begin
                    state <= IDLE;
                    if (is_drop) begin
                        parser_axis_rx_tdrop_o <= 1'b1;
                        if (drop_cnt_o != 32'hFFFF_FFFF) begin
                            drop_cnt_o <= drop_cnt_o + 32'd1;
                        end
                    end else begin
                        pkt_len_o   <= next_cnt;
                        hdr_len_o   <= win_len;
                        hdr_valid_o <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sdn_parser_hdr_fetch.sv
// tb/tb_sdn_parser_hdr_fetch.sv - scoreboard bench for sdn_parser_hdr_fetch (backpressure and drop-mode instances)
module tb_sdn_parser_hdr_fetch;

    localparam int W  = 512;
    localparam int K  = 64;
    localparam int HW = 1024;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          tvalid    [2];
    logic [W-1:0]  tdata     [2];
    logic [K-1:0]  tkeep     [2];
    logic          tlast     [2];
    logic          tready    [2];
    logic          tdrop     [2];
    logic          hdr_valid [2];
    logic          hdr_ready [2];
    logic [HW-1:0] hdr_data  [2];
    logic [15:0]   hdr_len   [2];
    logic [15:0]   pkt_len   [2];
    logic [31:0]   drop_cnt  [2];

    sdn_parser_hdr_fetch u_dut0 (
        .clk(clk), .resetn(resetn),
        .parser_axis_rx_tvalid_i(tvalid[0]), .parser_axis_rx_tdata_i(tdata[0]),
        .parser_axis_rx_tkeep_i(tkeep[0]), .parser_axis_rx_tlast_i(tlast[0]),
        .parser_axis_rx_tready_o(tready[0]), .parser_axis_rx_tdrop_o(tdrop[0]),
        .hdr_valid_o(hdr_valid[0]), .hdr_ready_i(hdr_ready[0]), .hdr_data_o(hdr_data[0]),
        .hdr_len_o(hdr_len[0]), .pkt_len_o(pkt_len[0]), .drop_cnt_o(drop_cnt[0])
    );

    sdn_parser_hdr_fetch #(.DROP_MODE(1)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .parser_axis_rx_tvalid_i(tvalid[1]), .parser_axis_rx_tdata_i(tdata[1]),
        .parser_axis_rx_tkeep_i(tkeep[1]), .parser_axis_rx_tlast_i(tlast[1]),
        .parser_axis_rx_tready_o(tready[1]), .parser_axis_rx_tdrop_o(tdrop[1]),
        .hdr_valid_o(hdr_valid[1]), .hdr_ready_i(hdr_ready[1]), .hdr_data_o(hdr_data[1]),
        .hdr_len_o(hdr_len[1]), .pkt_len_o(pkt_len[1]), .drop_cnt_o(drop_cnt[1])
    );

    typedef struct {
        int            dut;
        bit            drop;
        logic [15:0]   plen;
        logic [15:0]   hlen;
        logic [HW-1:0] hdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_valid [2];
    logic prev_ready [2];

    // A header event is a valid that is new (rising, or re-raised right after an accept) or a drop pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   fb;
        for (int d = 0; d < 2; d++) begin
            if (resetn && ((hdr_valid[d] && (!prev_valid[d] || prev_ready[d])) || tdrop[d])) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_event dut%0d: valid=%b drop=%b, none expected", d, hdr_valid[d], tdrop[d]);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (e.dut != d) begin
                        n_bad++;
                        $display("FAIL event_dut: got dut%0d, expected dut%0d", d, e.dut);
                    end
                    n_cmp++;
                    if (tdrop[d] !== e.drop) begin
                        n_bad++;
                        $display("FAIL drop_flag dut%0d: got %b, expected %b", d, tdrop[d], e.drop);
                    end else if (!e.drop) begin
                        n_cmp++;
                        if (pkt_len[d] !== e.plen) begin
                            n_bad++;
                            $display("FAIL pkt_len dut%0d: got %0d, expected %0d", d, pkt_len[d], e.plen);
                        end
                        n_cmp++;
                        if (hdr_len[d] !== e.hlen) begin
                            n_bad++;
                            $display("FAIL hdr_len dut%0d: got %0d, expected %0d", d, hdr_len[d], e.hlen);
                        end
                        n_cmp++;
                        if (hdr_data[d] !== e.hdata) begin
                            n_bad++;
                            fb = 0;
                            while (fb < 127 && hdr_data[d][fb*8 +: 8] === e.hdata[fb*8 +: 8]) fb++;
                            $display("FAIL hdr_data dut%0d: byte %0d got %h, expected %h", d, fb,
                                     hdr_data[d][fb*8 +: 8], e.hdata[fb*8 +: 8]);
                        end
                    end
                end
            end
            prev_valid[d] = hdr_valid[d];
            prev_ready[d] = hdr_ready[d];
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_beat(input int d, input logic [W-1:0] data, input logic [K-1:0] keep, input logic last);
        int n;
        tvalid[d] = 1'b1; tdata[d] = data; tkeep[d] = keep; tlast[d] = last;
        n = 0;
        @(negedge clk);
        while (!tready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL tready_timeout dut%0d: tready=%b, expected 1 within 100 cycles", d, tready[d]);
        end
        @(posedge clk); #1;
        tvalid[d] = 1'b0; tlast[d] = 1'b0;
    endtask

    task automatic send_pkt(input int d, input int nbeats, input int lastbytes, input bit exp_drop,
                            output logic [HW-1:0] hd);
        logic [W-1:0] bd [8];
        logic [K-1:0] lk;
        exp_t         e;
        int           len;
        len = (nbeats - 1) * K + lastbytes;
        for (int b = 0; b < nbeats; b++)
            for (int w = 0; w < W / 32; w++) bd[b][w*32 +: 32] = $urandom;
        hd = '0;
        for (int i = 0; i < len && i < 2 * K; i++) hd[i*8 +: 8] = bd[i / K][(i % K) * 8 +: 8];
        lk = '0;
        for (int i = 0; i < lastbytes; i++) lk[i] = 1'b1;
        e.dut = d; e.drop = exp_drop || (len < 14);
        e.plen = 16'(len); e.hlen = 16'((len < 2 * K) ? len : 2 * K); e.hdata = hd;
        sb.push_back(e);
        for (int b = 0; b < nbeats; b++)
            send_beat(d, bd[b], (b == nbeats - 1) ? lk : '1, b == nbeats - 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL result_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (tready[d] !== 1'b1 || tdrop[d] !== 1'b0 || hdr_valid[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_ctrl dut%0d: tready=%b tdrop=%b valid=%b, expected 1 0 0", tag, d, tready[d], tdrop[d], hdr_valid[d]);
            end
            n_cmp++;
            if (hdr_data[d] !== '0 || hdr_len[d] !== 16'd0 || pkt_len[d] !== 16'd0 || drop_cnt[d] !== 32'd0) begin
                n_bad++;
                $display("FAIL %s_regs dut%0d: hdr_len=%0d pkt_len=%0d drop_cnt=%0d data_nonzero=%b, expected all 0",
                         tag, d, hdr_len[d], pkt_len[d], drop_cnt[d], hdr_data[d] !== '0);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_single();
        logic [HW-1:0] hd;
        send_pkt(0, 1, 60, 0, hd);
        n_cmp++;
        if (hdr_valid[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency: hdr_valid=%b one cycle after tlast, expected 1", hdr_valid[0]);
        end
        n_cmp++;
        if (hdr_data[0][HW-1:W] !== '0) begin
            n_bad++;
            $display("FAIL single_upper_zero: bytes 64..127 nonzero, expected 0");
        end
        wait_done();
    endtask

    task automatic test_multi();
        logic [HW-1:0] hd;
        send_pkt(0, 5, 4, 0, hd);
        wait_done();
        send_pkt(0, 3, 0, 0, hd);
        wait_done();
        send_pkt(0, 2, 1, 0, hd);
        wait_done();
    endtask

    task automatic test_runt();
        logic [HW-1:0] hd;
        logic [31:0]   base;
        base = drop_cnt[0];
        send_pkt(0, 1, 10, 0, hd);
        send_pkt(0, 1, 13, 0, hd);
        send_pkt(0, 1, 14, 0, hd);
        wait_done();
        n_cmp++;
        if (drop_cnt[0] !== base + 32'd2) begin
            n_bad++;
            $display("FAIL runt_drop_cnt: got %0d, expected %0d", drop_cnt[0], base + 32'd2);
        end
    endtask

    task automatic test_back_to_back();
        logic [HW-1:0] hd;
        int nb, lb;
        for (int i = 0; i < 8; i++) begin
            nb = $urandom_range(1, 4);
            lb = (nb == 1) ? $urandom_range(14, 64) : $urandom_range(0, 64);
            send_pkt(0, nb, lb, 0, hd);
        end
        wait_done();
    endtask

    task automatic test_backpressure();
        logic [HW-1:0] hda, hdb;
        hdr_ready[0] = 1'b0;
        send_pkt(0, 2, 30, 0, hda);
        fork
            send_pkt(0, 1, 40, 0, hdb);
            begin
                repeat (4) begin
                    @(negedge clk);
                    n_cmp++;
                    if (tready[0] !== 1'b0 || hdr_valid[0] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL bp_stall: tready=%b valid=%b, expected 0 1", tready[0], hdr_valid[0]);
                    end
                    n_cmp++;
                    if (hdr_data[0] !== hda) begin
                        n_bad++;
                        $display("FAIL bp_hold: held header changed while not accepted");
                    end
                end
                @(posedge clk); #1;
                hdr_ready[0] = 1'b1;
                @(negedge clk);
                n_cmp++;
                if (tready[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL bp_release: tready=%b with hdr_ready=1, expected 1", tready[0]);
                end
            end
        join
        wait_done();
    endtask

    task automatic test_drop_mode();
        logic [HW-1:0] hda, hdb;
        hdr_ready[1] = 1'b0;
        send_pkt(1, 2, 50, 0, hda);
        send_pkt(1, 3, 20, 1, hdb);
        wait_done();
        n_cmp++;
        if (drop_cnt[1] !== 32'd1) begin
            n_bad++;
            $display("FAIL dm_drop_cnt: got %0d, expected 1", drop_cnt[1]);
        end
        n_cmp++;
        if (hdr_valid[1] !== 1'b1 || hdr_data[1] !== hda || pkt_len[1] !== 16'd114) begin
            n_bad++;
            $display("FAIL dm_first_kept: valid=%b pkt_len=%0d data_ok=%b, expected 1 114 1",
                     hdr_valid[1], pkt_len[1], hdr_data[1] === hda);
        end
        hdr_ready[1] = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (hdr_valid[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL dm_accept: hdr_valid=%b after accept, expected 0", hdr_valid[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [HW-1:0] hd;
        send_beat(0, {16{$urandom}}, '1, 1'b0);
        send_beat(0, {16{$urandom}}, '1, 1'b0);
        tvalid[0] = 1'b1; tdata[0] = {16{$urandom}}; tkeep[0] = '1; tlast[0] = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; tvalid[0] = 1'b0;
        @(negedge clk);
        check_reset_values("reset_mid");
        @(posedge clk); #1;
        send_pkt(0, 1, 60, 0, hd);
        wait_done();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            tvalid[d] = 1'b0; tdata[d] = '0; tkeep[d] = '0; tlast[d] = 1'b0; hdr_ready[d] = 1'b1;
        end
        test_reset();
        test_single();
        test_multi();
        test_runt();
        test_back_to_back();
        test_backpressure();
        test_drop_mode();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdn_parser_hdr_fetch.md
# sdn_parser_hdr_fetch

Parametrised header fetch unit at the ingress of the SDN parser. It accepts packets on an AXI-Stream RX interface and captures the first HDR_BEATS beats into a header window. At packet end it presents that window to the parser stage with byte counts over a valid/ready handshake. Runt packets, and (in drop mode) packets arriving while the header slot is occupied, are discarded with a drop pulse and a counter.

## Interface
- PRS_RX_DATA_W, 512: RX beat width in bits (multiple of 8).
- PRS_RX_KEEP_W, PRS_RX_DATA_W/8: tkeep width (bytes per beat).
- HDR_BEATS, 2: beats captured into the header window; HDR_W = HDR_BEATS*PRS_RX_DATA_W.
- LEN_W, 16: packet length counter width.
- MIN_PKT_BYTES, 14: packets shorter than this are dropped as runts.
- DROP_MODE, 0: 0 = backpressure when header slot full; 1 = keep tready high and drop.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- parser_axis_rx_tvalid_i  in  1  RX beat valid.
- parser_axis_rx_tdata_i  in  PRS_RX_DATA_W  RX data; packet byte 0 is tdata[7:0] of the first beat.
- parser_axis_rx_tkeep_i  in  PRS_RX_KEEP_W  byte enables, contiguous from bit 0; only used on the tlast beat.
- parser_axis_rx_tlast_i  in  1  last beat of packet.
- parser_axis_rx_tready_o  out  1  RX ready.
- parser_axis_rx_tdrop_o  out  1  one-cycle pulse: the packet just completed was dropped.
- hdr_valid_o  out  1  header window valid.
- hdr_ready_i  in  1  parser accepts header.
- hdr_data_o  out  HDR_W  header window; beat k occupies [k*PRS_RX_DATA_W +: PRS_RX_DATA_W]; bytes past packet end are 0.
- hdr_len_o  out  LEN_W  bytes valid in the window = min(pkt_len, HDR_BEATS*PRS_RX_KEEP_W).
- pkt_len_o  out  LEN_W  total packet bytes, saturating at 2^LEN_W-1.
- drop_cnt_o  out  32  dropped-packet count, saturating.

## Operation
- Beat handshake: tvalid_i && tready_o.
- States:
  - IDLE: waiting for the first beat.
  - CAPT: capturing header beats.
  - SKIP: consuming beats past the window.
  - DROP: discarding the whole packet.
- First beat in IDLE:
  - DROP_MODE=1 and hdr_valid_o=1 → DROP.
  - Otherwise clear the window, write beat 0, beat index = 1, and go to CAPT (or SKIP if HDR_BEATS=1).
- CAPT: write the beat at the beat index, increment the index; go to SKIP when the index reaches HDR_BEATS. SKIP/DROP: data ignored.
- Byte count: a non-last beat adds PRS_RX_KEEP_W. The tlast beat adds popcount(tkeep). The count saturates.
- tlast beat, any state:
  - Final count < MIN_PKT_BYTES, or state DROP → pulse tdrop_o, increment drop_cnt_o, hdr_valid_o unchanged.
  - Otherwise latch pkt_len_o/hdr_len_o and set hdr_valid_o.
  - Next state is IDLE in both cases.
- Only one packet is in flight. hdr_valid_o can only be 1 at packet start, so the window register is never overwritten while valid in accepting states.
- hdr_valid_o clears on hdr_valid_o && hdr_ready_i. hdr_data_o, hdr_len_o and pkt_len_o hold stable while valid and not accepted.
- Zero keep on the tlast beat is legal (adds 0 bytes).

## Timing
- Reset values:
  - tready_o = 1 (combinational, see below).
  - tdrop_o = 0, hdr_valid_o = 0.
  - hdr_data_o, hdr_len_o, pkt_len_o = 0.
  - drop_cnt_o = 0; state IDLE.
- tready_o = 1 except in IDLE with DROP_MODE=0, hdr_valid_o=1 and hdr_ready_i=0. This is a combinational path from hdr_ready_i, and allows back-to-back packets with no bubble.
- Latency: hdr_valid_o (or tdrop_o) rises the cycle after the tlast handshake. A single-beat packet yields valid one cycle after its beat.
- Header accept and first beat of the next packet in the same cycle: both take effect; the window is cleared and rewritten.
- Reset mid-packet: all state returns to reset values; subsequent beats are treated as a new packet start.

## Test plan
- Single-beat packet, W=512, 60 bytes (tkeep low 60 bits), tlast → next cycle hdr_valid_o=1, pkt_len_o=60, hdr_len_o=60, hdr bytes 64..127 = 0.
- 5-beat packet, last tkeep=0xF → pkt_len_o=260, hdr_len_o=128, hdr_data_o = beats 0–1; beats 2–4 not captured.
- DROP_MODE=0, hdr_ready_i held 0, second packet offered → tready_o=0 until hdr_ready_i=1; the second packet is then accepted in the same cycle.
- DROP_MODE=1, same stimulus → second packet accepted, tdrop_o pulses after its tlast, drop_cnt_o=1, first header unchanged and still valid.
- 10-byte runt single beat → no hdr_valid_o, tdrop_o pulse, drop_cnt_o increments.
- resetn low during beat 2 of a 4-beat packet → all outputs reset; the next beat is treated as a new packet start.
